// File: rtl/rv32i_pkg.sv
// Shared RV32I datapath widths and the writeback request record.
package rv32i_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans from rr_ptr, grants the first valid requester,
// then advances the pointer past the winner.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic                 ena,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx,
   output logic                 grant_valid
);

   localparam int IDX_W = $clog2(N);

   logic [IDX_W-1:0] rr_ptr_q;
   logic [IDX_W-1:0] rr_ptr_d;
   logic             found;
   int               scan_idx;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      scan_idx  = 0;
      for (int k = 0; k < N; k++) begin
         scan_idx = (int'(rr_ptr_q) + k) % N;
         if (!found && req[scan_idx]) begin
            found     = 1'b1;
            grant_idx = IDX_W'(scan_idx);
         end
      end
      grant_valid = ena & found;
      grant       = grant_valid ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;

      rr_ptr_d = rr_ptr_q;
      if (grant_valid) begin
         rr_ptr_d = (grant_idx == IDX_W'(N-1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among N_REQ writeback sources through a
// one-entry buffer; drops x0 writes and flags read-after-write hazards to decode.
module regfile_wb_arbiter
   import rv32i_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*REG_ADDR_W-1:0] req_addr,
   input  logic [N_REQ*XLEN-1:0]       req_data,
   output logic [N_REQ-1:0]            req_ready,
   input  logic                        wb_stall,
   output logic                        wr_ena,
   output logic [REG_ADDR_W-1:0]       wr_addr,
   output logic [XLEN-1:0]             wr_data,
   input  logic [REG_ADDR_W-1:0]       rd_addr0,
   input  logic [REG_ADDR_W-1:0]       rd_addr1,
   output logic                        hazard0,
   output logic                        hazard1,
   output logic [XLEN-1:0]             fwd_data
);

   localparam int IDX_W = $clog2(N_REQ);

   logic             grant_valid;
   logic [IDX_W-1:0] grant_idx;
   logic             arb_ena;
   wb_req_t          win_req;
   wb_req_t          buf_q, buf_d;
   logic             buf_valid_q, buf_valid_d;

   // The buffer drains every unstalled cycle, so acceptance only waits on the stall.
   // Holding off grants while in reset keeps requesters from losing a write.
   assign arb_ena = ~wb_stall & rst;

   rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
      .clk        (clk),
      .rst        (rst),
      .req        (req_valid),
      .ena        (arb_ena),
      .grant      (req_ready),
      .grant_idx  (grant_idx),
      .grant_valid(grant_valid)
   );

   always_comb begin
      win_req.addr = req_addr[int'(grant_idx)*REG_ADDR_W +: REG_ADDR_W];
      win_req.data = req_data[int'(grant_idx)*XLEN +: XLEN];

      buf_d       = buf_q;
      buf_valid_d = buf_valid_q;
      if (!wb_stall) begin
         buf_valid_d = 1'b0;
         if (grant_valid && win_req.addr != '0) begin
            buf_valid_d = 1'b1;
            buf_d       = win_req;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         buf_valid_q <= 1'b0;
         buf_q       <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_q       <= buf_d;
      end
   end

   // A pending write is suppressed while reset is asserted so it can never land.
   assign wr_ena   = buf_valid_q & ~wb_stall & rst;
   assign wr_addr  = buf_q.addr;
   assign wr_data  = buf_q.data;

   assign hazard0  = buf_valid_q & (buf_q.addr == rd_addr0) & (rd_addr0 != '0);
   assign hazard1  = buf_valid_q & (buf_q.addr == rd_addr1) & (rd_addr1 != '0);
   assign fwd_data = buf_valid_q ? buf_q.data : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a small register-file model on its write port.
module tb_regfile_wb_arbiter;

   localparam int N_REQ = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [N_REQ-1:0]  req_valid;
   logic [N_REQ*5-1:0]  req_addr;
   logic [N_REQ*32-1:0] req_data;
   logic [N_REQ-1:0]  req_ready;
   logic              wb_stall;
   logic              wr_ena;
   logic [4:0]        wr_addr;
   logic [31:0]       wr_data;
   logic [4:0]        rd_addr0, rd_addr1;
   logic              hazard0, hazard1;
   logic [31:0]       fwd_data;

   logic [31:0]       rf_mdl [32];

   int checks   = 0;
   int failures = 0;

   regfile_wb_arbiter #(.N_REQ(N_REQ)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_addr (req_addr),
      .req_data (req_data),
      .req_ready(req_ready),
      .wb_stall (wb_stall),
      .wr_ena   (wr_ena),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr0 (rd_addr0),
      .rd_addr1 (rd_addr1),
      .hazard0  (hazard0),
      .hazard1  (hazard1),
      .fwd_data (fwd_data)
   );

   always #5 clk = ~clk;

   initial for (int r = 0; r < 32; r++) rf_mdl[r] = 32'h0;

   always @(posedge clk) begin
      if (wr_ena) rf_mdl[wr_addr] <= wr_data;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
   endtask

   task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
      req_valid[i]        = 1'b1;
      req_addr[i*5 +: 5]  = a;
      req_data[i*32 +: 32] = d;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_reqs();
      wb_stall = 1'b0;
      tick();
      rst = 1'b1;
      #1;
   endtask

   initial begin
      rst      = 1'b0;
      wb_stall = 1'b0;
      rd_addr0 = '0;
      rd_addr1 = '0;
      clear_reqs();

      // 1 Reset with every requester valid
      for (int i = 0; i < N_REQ; i++) set_req(i, 5'(i + 1), 32'hA0 + i + 1);
      rd_addr0 = 5'd1;
      rd_addr1 = 5'd2;
      tick();
      check("rst_ready", 32'(req_ready), 32'h0);
      check("rst_wr_ena", 32'(wr_ena), 32'h0);
      check("rst_haz0", 32'(hazard0), 32'h0);
      check("rst_haz1", 32'(hazard1), 32'h0);
      check("rst_fwd", fwd_data, 32'h0);
      check("rst_wr_addr", 32'(wr_addr), 32'h0);
      rst = 1'b1;
      #1;
      check("rst_first_grant", 32'(req_ready), 32'h1);

      // 2 Fairness: rotation 0,1,2,3,0,1 with writes trailing by one cycle
      check("fair_wr_ena0", 32'(wr_ena), 32'h0);
      for (int c = 1; c < 7; c++) begin
         tick();
         check("fair_ready", 32'(req_ready), 32'(4'b0001 << (c % 4)));
         check("fair_wr_ena", 32'(wr_ena), 32'h1);
         check("fair_wr_addr", 32'(wr_addr), 32'(((c - 1) % 4) + 1));
         check("fair_wr_data", wr_data, 32'hA0 + ((c - 1) % 4) + 1);
      end
      check("fair_rf_x1", rf_mdl[1], 32'hA1);
      check("fair_rf_x4", rf_mdl[4], 32'hA4);

      // 3 x0 write is consumed but never issued
      do_reset();
      set_req(1, 5'd0, 32'hDEADBEEF);
      #1;
      check("x0_ready", 32'(req_ready), 32'h2);
      tick();
      clear_reqs();
      #1;
      check("x0_wr_ena", 32'(wr_ena), 32'h0);
      tick();
      check("x0_rf", rf_mdl[0], 32'h0);

      // 4 Stall holds the buffered write and keeps hazards visible
      do_reset();
      set_req(0, 5'd5, 32'h12345678);
      #1;
      check("stall_acc", 32'(req_ready), 32'h1);
      tick();
      clear_reqs();
      set_req(2, 5'd9, 32'h99);
      wb_stall = 1'b1;
      rd_addr0 = 5'd5;
      rd_addr1 = 5'd5;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("stall_wr_ena", 32'(wr_ena), 32'h0);
         check("stall_ready", 32'(req_ready), 32'h0);
         check("stall_haz0", 32'(hazard0), 32'h1);
         check("stall_fwd", fwd_data, 32'h12345678);
         tick();
      end
      check("stall_haz1", 32'(hazard1), 32'h1);
      clear_reqs();
      wb_stall = 1'b0;
      #1;
      check("rel_wr_ena", 32'(wr_ena), 32'h1);
      check("rel_wr_addr", 32'(wr_addr), 32'h5);
      check("rel_wr_data", wr_data, 32'h12345678);
      tick();
      check("rel_once", 32'(wr_ena), 32'h0);
      check("rel_haz0_clr", 32'(hazard0), 32'h0);
      check("rel_rf_x5", rf_mdl[5], 32'h12345678);
      rd_addr0 = '0;
      rd_addr1 = '0;

      // 5 Pointer wrap: req3 then req0, no bubble, then pointer sits at 1
      do_reset();
      set_req(3, 5'd3, 32'h33);
      #1;
      check("wrap_r3", 32'(req_ready), 32'h8);
      tick();
      clear_reqs();
      set_req(0, 5'd10, 32'h100);
      #1;
      check("wrap_r0", 32'(req_ready), 32'h1);
      check("wrap_wr_addr", 32'(wr_addr), 32'h3);
      tick();
      set_req(1, 5'd11, 32'h111);
      #1;
      check("wrap_ptr1", 32'(req_ready), 32'h2);
      check("wrap_nobubble", 32'(wr_addr), 32'hA);

      // 6 Reset while a write is buffered discards it
      do_reset();
      set_req(2, 5'd7, 32'hCAFEF00D);
      #1;
      check("mid_acc", 32'(req_ready), 32'h4);
      tick();
      clear_reqs();
      rst = 1'b0;
      #1;
      check("mid_wr_ena_rst", 32'(wr_ena), 32'h0);
      tick();
      rst = 1'b1;
      #1;
      check("mid_wr_ena_after", 32'(wr_ena), 32'h0);
      check("mid_fwd", fwd_data, 32'h0);
      tick();
      check("mid_rf_x7", rf_mdl[7], 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
